demux2: RTL and testbench
=========================

DEMUX2 -- requirements
Module: demux2

Interface
REQ-001 Parameter DIGITS, default 4: BCD digits per frame and per output bank.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_  input  1  reset is asynchronous and active-low.
REQ-004 sel  input  1  bank select, sampled only on the start-of-frame beat: 1 selects bank 1 (Out1), 0 selects bank 2 (Out2).
REQ-005 in_valid  input  1  a digit beat is present on In this cycle.
REQ-006 in_sof  input  1  start of frame; meaningful only when in_valid=1.
REQ-007 In  input  4  BCD digit, most-significant digit first.
REQ-008 Out1  output  4*DIGITS  registered bank 1; digit 0 of the frame lands in the top nibble.
REQ-009 Out2  output  4*DIGITS  registered bank 2, same packing as Out1.
REQ-010 upd1  output  1  one-cycle pulse: Out1 took a new value this cycle.
REQ-011 upd2  output  1  one-cycle pulse: Out2 took a new value this cycle.
REQ-012 err  output  1  one-cycle pulse: the current frame was discarded.

Function
REQ-013 The FSM shall have two states, IDLE and COLLECT, plus a digit counter of width ceil(log2(DIGITS)).
REQ-014 IDLE, beat with in_sof=1 and a valid digit: latch sel into sel_q, store the digit in shadow slot 0, set count=1, go to COLLECT.
REQ-015 IDLE, beat with in_sof=0: ignore it; no state, output or err change.
REQ-016 COLLECT, beat with in_sof=0 and a valid digit: store in shadow slot count, then increment count.
REQ-017 Frame completion: when the beat holding digit DIGITS-1 is accepted, the full shadow value shall be committed atomically to the bank chosen by sel_q on the next rising edge.
- On that same edge, the matching upd pulse goes high for one cycle, and the FSM returns to IDLE.
REQ-018 Latency: Out1/Out2 and upd1/upd2 change in the cycle after the final beat is sampled, never earlier.
REQ-019 Cycles with in_valid=0 inside a frame are gaps: state held, no timeout.
REQ-020 Changes on sel after the SOF beat shall have no effect on the frame in progress.
REQ-021 Digit greater than 9 in any state where it would be stored: discard the frame, pulse err, go to IDLE, and leave both banks unchanged.
REQ-022 An invalid digit on an IDLE SOF beat shall pulse err and stay in IDLE.
REQ-023 COLLECT, beat with in_sof=1 (restart): pulse err for the abandoned partial frame, then start a new frame from this beat with a fresh sel sample.
- This is the same as REQ-014, but the FSM stays in COLLECT.
REQ-024 Restart with an invalid digit shall pulse err once and go to IDLE.
REQ-025 The bank that is not selected shall hold its value on every cycle.
REQ-026 upd1, upd2 and err shall never be high for more than one consecutive cycle per event.
REQ-027 upd1 and upd2 shall never be high in the same cycle.
REQ-028 With DIGITS=1, every valid SOF beat is also a complete frame (the beat is both first and last).
REQ-029 All outputs shall be driven straight from flops; no combinational path from any input to any output.

Reset
REQ-030 While reset_=0, the following shall be cleared asynchronously:
- Out1, Out2, shadow register: 0.
- upd1, upd2, err: 0.
- FSM: IDLE; count: 0; sel_q: 0.
REQ-031 Reset asserted mid-frame shall discard the partial frame without an err pulse.
REQ-032 The first rising edge after reset_ deasserts shall process inputs normally, including accepting an SOF beat on that edge.

Verification
REQ-033 Basic routing to bank 1: sel=1, SOF beats 1,2,3,4 on consecutive cycles -> the cycle after the 4th beat, Out1=16'h1234 and upd1=1 for one cycle; Out2=0; upd2 and err stay 0.
REQ-034 Gaps and late sel change: sel=0 on the SOF beat, digits 0,9,5,9 with idle gaps, sel toggled to 1 mid-frame -> Out2=16'h0959, upd2 pulses once; Out1 unchanged.
REQ-035 Invalid digit: frame 7,8,4'hA -> err pulses the cycle after the 4'hA beat, FSM back in IDLE, both banks unchanged; a following valid frame 1,1,1,1 with sel=1 commits 16'h1111.
REQ-036 Restart: sel=1, SOF with 3,3, then SOF with sel=0 and 2,2,2,2 -> one err pulse on the restart; Out2=16'h2222; Out1 unchanged.
REQ-037 Orphan beats: beats without SOF while in IDLE -> no outputs change, no err.
REQ-038 Reset mid-frame: reset_ pulsed low after 2 beats of a frame -> all outputs 0, no err; a subsequent full frame commits correctly.

Source files
------------

// File: rtl/demux2.sv
// Collects DIGITS BCD digits per frame (MSD first) and commits the frame atomically to Out1 or Out2.
// Latency: bank and upd pulse appear the cycle after the final beat; err appears the cycle after the offending beat.
// No backpressure: every valid beat is consumed; gaps (in_valid=0) hold state indefinitely.
module demux2 #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic                  sel,
    input  logic                  in_valid,
    input  logic                  in_sof,
    input  logic [3:0]            In,
    output logic [4*DIGITS-1:0]   Out1,
    output logic [4*DIGITS-1:0]   Out2,
    output logic                  upd1,
    output logic                  upd2,
    output logic                  err
);

    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t              state, state_d;
    logic [CW-1:0]       count, count_d;
    logic                sel_q, sel_q_d;
    logic [4*DIGITS-1:0] shadow, shadow_d;
    logic [4*DIGITS-1:0] out1_d, out2_d;
    logic                upd1_d, upd2_d, err_d;
    logic                commit, commit_sel;
    logic                digit_ok;
    logic [CW-1:0]       slot;
    logic [4*DIGITS-1:0] merged;

    assign digit_ok = (In <= 4'd9);
    assign slot     = in_sof ? '0 : count;

    // Shadow with the incoming digit already placed, so the last beat can commit on its own sampling edge.
    always_comb begin
        merged = shadow;
        for (int i = 0; i < DIGITS; i++) begin
            if (CW'(i) == slot) begin
                merged[4*(DIGITS-1-i) +: 4] = In;
            end
        end
    end

    always_comb begin
        state_d    = state;
        count_d    = count;
        sel_q_d    = sel_q;
        shadow_d   = shadow;
        out1_d     = Out1;
        out2_d     = Out2;
        upd1_d     = 1'b0;
        upd2_d     = 1'b0;
        err_d      = 1'b0;
        commit     = 1'b0;
        commit_sel = sel_q;

        if (in_valid) begin
            if (in_sof) begin
                if (!digit_ok) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                    count_d = '0;
                end else begin
                    // A restart abandons the partial frame but the new one begins on this very beat.
                    err_d    = (state == COLLECT);
                    sel_q_d  = sel;
                    shadow_d = merged;
                    if (DIGITS == 1) begin
                        commit     = 1'b1;
                        commit_sel = sel;
                        state_d    = IDLE;
                        count_d    = '0;
                    end else begin
                        count_d = CW'(1);
                        state_d = COLLECT;
                    end
                end
            end else if (state == COLLECT) begin
                if (!digit_ok) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                    count_d = '0;
                end else begin
                    shadow_d = merged;
                    if (count == LAST) begin
                        commit  = 1'b1;
                        state_d = IDLE;
                        count_d = '0;
                    end else begin
                        count_d = count + 1'b1;
                    end
                end
            end
        end

        if (commit) begin
            if (commit_sel) begin
                out1_d = merged;
                upd1_d = 1'b1;
            end else begin
                out2_d = merged;
                upd2_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state  <= IDLE;
            count  <= '0;
            sel_q  <= 1'b0;
            shadow <= '0;
            Out1   <= '0;
            Out2   <= '0;
            upd1   <= 1'b0;
            upd2   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_d;
            count  <= count_d;
            sel_q  <= sel_q_d;
            shadow <= shadow_d;
            Out1   <= out1_d;
            Out2   <= out2_d;
            upd1   <= upd1_d;
            upd2   <= upd2_d;
            err    <= err_d;
        end
    end

endmodule

// File: tb/tb_demux2.sv
// Randomized and directed stimulus for demux2; a frame-level model queues expected events,
// and a negedge monitor pops and compares them whenever the DUT pulses upd1/upd2/err.
module tb_demux2;

    localparam int D = 4;
    localparam int W = 4 * D;

    logic         clk      = 1'b0;
    logic         reset_   = 1'b0;
    logic         sel      = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_sof   = 1'b0;
    logic [3:0]   In       = 4'd0;
    logic [W-1:0] Out1, Out2;
    logic         upd1, upd2, err;

    demux2 #(.DIGITS(D)) dut (
        .clk      (clk),
        .reset_   (reset_),
        .sel      (sel),
        .in_valid (in_valid),
        .in_sof   (in_sof),
        .In       (In),
        .Out1     (Out1),
        .Out2     (Out2),
        .upd1     (upd1),
        .upd2     (upd2),
        .err      (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // kind: 0 = err, 1 = bank 1 update, 2 = bank 2 update; o1/o2 are bank contents after the event
    typedef struct {
        int           kind;
        logic [W-1:0] o1;
        logic [W-1:0] o2;
        int           at;
    } ev_t;

    ev_t          evq[$];
    logic [W-1:0] m1 = '0, m2 = '0;
    bit           m_active = 1'b0;
    bit           m_sel    = 1'b0;
    int           m_dig[$];

    function automatic logic [2:0] onehot(input int kind);
        return (kind == 1) ? 3'b100 : (kind == 2) ? 3'b010 : 3'b001;
    endfunction

    function automatic void push_ev(input int kind);
        ev_t e;
        e.kind = kind;
        e.o1   = m1;
        e.o2   = m2;
        e.at   = cyc + 1;
        evq.push_back(e);
    endfunction

    // Frame-level reference: a frame is a list of digits; it completes when it holds D of them.
    function automatic void model_step(input bit v, input bit sof, input bit s, input int d);
        int value;
        if (!v) return;
        if (sof) begin
            if (d > 9) begin
                m_active = 1'b0;
                push_ev(0);
            end else begin
                if (m_active) push_ev(0);
                m_active = 1'b1;
                m_sel    = s;
                m_dig    = {d};
            end
        end else if (m_active) begin
            if (d > 9) begin
                m_active = 1'b0;
                push_ev(0);
            end else begin
                m_dig.push_back(d);
            end
        end
        if (m_active && m_dig.size() == D) begin
            value = 0;
            foreach (m_dig[i]) value = value * 16 + m_dig[i];
            if (m_sel) begin
                m1 = W'(value);
                push_ev(1);
            end else begin
                m2 = W'(value);
                push_ev(2);
            end
            m_active = 1'b0;
        end
    endfunction

    // Called at posedge+1: drives one beat, then advances to the next posedge+1.
    task automatic beat(input bit v, input bit sof, input bit s, input logic [3:0] d);
        in_valid = v;
        in_sof   = sof;
        sel      = s;
        In       = d;
        model_step(v, sof, s, int'(d));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic frame(input bit s, input logic [15:0] digs);
        logic [15:0] t;
        t = digs;
        for (int i = 0; i < 4; i++) beat(1'b1, i == 0, s, t[15-4*i -: 4]);
    endtask

    // Leaves reset_ high at posedge+1 so the next beat is sampled on the first edge after release.
    task automatic do_reset();
        idle(1);
        reset_   = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        m1       = '0;
        m2       = '0;
        m_active = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_ = 1'b1;
    endtask

    logic [W-1:0] e1 = '0, e2 = '0;

    always @(negedge clk) begin
        ev_t ev;
        if (!reset_) begin
            e1 = '0;
            e2 = '0;
            chk("reset_out1", 32'(Out1), 32'd0);
            chk("reset_out2", 32'(Out2), 32'd0);
            chk("reset_pulses", 32'({upd1, upd2, err}), 32'd0);
        end else begin
            if (upd1 | upd2 | err) begin
                if (evq.size() == 0) begin
                    chk("unexpected_pulse", 32'({upd1, upd2, err}), 32'd0);
                end else begin
                    ev = evq.pop_front();
                    chk("event_kind", 32'({upd1, upd2, err}), 32'(onehot(ev.kind)));
                    chk("event_latency", 32'(cyc), 32'(ev.at));
                    e1 = ev.o1;
                    e2 = ev.o2;
                end
            end else if (evq.size() > 0 && evq[0].at <= cyc) begin
                ev = evq.pop_front();
                chk("missed_pulse", 32'({upd1, upd2, err}), 32'(onehot(ev.kind)));
                e1 = ev.o1;
                e2 = ev.o2;
            end
            chk("out1", 32'(Out1), 32'(e1));
            chk("out2", 32'(Out2), 32'(e2));
        end
    end

    initial begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_ = 1'b1;

        // basic routing to bank 1
        frame(1'b1, 16'h1234);
        idle(1);
        chk("basic_out1", 32'(Out1), 32'h1234);
        chk("basic_out2", 32'(Out2), 32'h0000);

        // gaps inside the frame and sel toggled after the SOF beat
        beat(1'b1, 1'b1, 1'b0, 4'd0);
        idle(2);
        beat(1'b1, 1'b0, 1'b1, 4'd9);
        idle(1);
        beat(1'b1, 1'b0, 1'b1, 4'd5);
        idle(3);
        beat(1'b1, 1'b0, 1'b1, 4'd9);
        idle(1);
        chk("gap_out2", 32'(Out2), 32'h0959);
        chk("gap_out1", 32'(Out1), 32'h1234);

        // invalid digit discards the frame, then a clean frame follows
        beat(1'b1, 1'b1, 1'b1, 4'd7);
        beat(1'b1, 1'b0, 1'b1, 4'd8);
        beat(1'b1, 1'b0, 1'b1, 4'hA);
        idle(1);
        chk("bad_out1", 32'(Out1), 32'h1234);
        chk("bad_out2", 32'(Out2), 32'h0959);
        frame(1'b1, 16'h1111);
        idle(1);
        chk("after_bad_out1", 32'(Out1), 32'h1111);

        // restart mid-frame with a fresh sel
        beat(1'b1, 1'b1, 1'b1, 4'd3);
        beat(1'b1, 1'b0, 1'b1, 4'd3);
        frame(1'b0, 16'h2222);
        idle(1);
        chk("restart_out2", 32'(Out2), 32'h2222);
        chk("restart_out1", 32'(Out1), 32'h1111);

        // invalid SOF in IDLE, restart with invalid digit, orphan beats
        beat(1'b1, 1'b1, 1'b1, 4'hF);
        beat(1'b1, 1'b1, 1'b0, 4'd6);
        beat(1'b1, 1'b1, 1'b1, 4'hC);
        beat(1'b1, 1'b0, 1'b1, 4'd5);
        beat(1'b1, 1'b0, 1'b0, 4'd6);
        beat(1'b1, 1'b0, 1'b1, 4'hB);
        idle(1);
        chk("orphan_out1", 32'(Out1), 32'h1111);
        chk("orphan_out2", 32'(Out2), 32'h2222);

        // reset mid-frame, then a frame starting on the first edge after release
        beat(1'b1, 1'b1, 1'b1, 4'd4);
        beat(1'b1, 1'b0, 1'b1, 4'd5);
        do_reset();
        frame(1'b0, 16'h9876);
        idle(1);
        chk("post_reset_out2", 32'(Out2), 32'h9876);
        chk("post_reset_out1", 32'(Out1), 32'h0000);

        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                beat($urandom_range(0, 99) < 75,
                     $urandom_range(0, 99) < 20,
                     1'($urandom_range(0, 1)),
                     4'($urandom_range(0, 10 + ($urandom_range(0, 3) == 0 ? 5 : 0))));
            end
        end
        idle(4);
        chk("queue_drained", 32'(evq.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
